// File: rtl/store_narrow.sv
// store_narrow: narrow (byte/half/word) store engine driving a 32-bit word memory port.
// Latency: 2 cycles accept->done (ack in first WR cycle); 3 cycles for RMW byte/half.
// Backpressure: req_ready only in IDLE; mem strobes held until mem_ack; misaligned requests fault in IDLE.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        store request handshake
//   req_addr, req_data         byte address and register value (low bits significant)
//   req_size                   00 byte, 01 half, 10 word, 11 reserved (always faults)
//   mem_addr                   word address, bits [1:0] forced to 0
//   mem_we, mem_re             write / read strobes, held until mem_ack
//   mem_wdata, mem_be          write data and byte enables (lane k = bits 8k+7:8k)
//   mem_rdata, mem_ack         read data and completion
//   done, misalign             one-cycle completion / fault pulses
//
// Build option: define STORE_RMW_EN to target memory without byte enables.
// Byte and half stores then read the word first and write it back merged,
// and mem_be is always 4'b1111 during a write.

module store_narrow #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              misalign
);

`ifdef STORE_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-3:0]   waddr_q, waddr_d;   // word address only; byte offset lives in lane_q
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          lane_q,  lane_d;    // lanes actually being stored
  logic                done_q,  done_d;
  logic                mis_q,   mis_d;

  logic                req_misaligned;
  logic [31:0]         place_data;
  logic [3:0]          place_lane;
  logic [31:0]         merged_data;

  // Alignment check and lane placement of the incoming request.
  always_comb begin
    req_misaligned = 1'b0;
    place_data     = req_data;
    place_lane     = 4'b1111;
    case (req_size)
      2'b00: begin
        place_data = {4{req_data[7:0]}};
        place_lane = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        req_misaligned = req_addr[0];
        place_data     = {2{req_data[15:0]}};
        place_lane     = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        req_misaligned = |req_addr[1:0];
      end
      default: begin
        req_misaligned = 1'b1;
      end
    endcase
  end

  // Read-modify-write merge: stored lanes come from wdata_q, the rest from memory.
  always_comb begin
    merged_data = '0;
    for (int k = 0; k < 4; k++) begin
      merged_data[8*k +: 8] = lane_q[k] ? wdata_q[8*k +: 8] : mem_rdata[8*k +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // mem_ack is deliberately not looked at here: a stray ack is ignored.
        if (req_valid) begin
          if (req_misaligned) begin
            mis_d = 1'b1;
          end else begin
            waddr_d = req_addr[ADDR_W-1:2];
            wdata_d = place_data;
            lane_d  = place_lane;
            // Word stores overwrite every lane, so they never need the read.
            state_d = (RMW_EN && (req_size != 2'b10)) ? RD : WR;
          end
        end
      end
      RD: begin
        if (mem_ack) begin
          wdata_d = merged_data;
          state_d = WR;
        end
      end
      WR: begin
        if (mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: all decoded from registered state so reset clears them immediately.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_we    = (state_q == WR);
    mem_re    = (state_q == RD);
    mem_addr  = (state_q == IDLE) ? '0 : {waddr_q, 2'b00};
    mem_wdata = (state_q == WR) ? wdata_q : 32'h0;
    mem_be    = (state_q == WR) ? (RMW_EN ? 4'b1111 : lane_q) : 4'b0000;
    done      = done_q;
    misalign  = mis_q;
  end

endmodule

// File: tb/tb_store_narrow.sv
// tb_store_narrow: directed stimulus with a scoreboard of expected memory/done/fault events.
// Latency: checked explicitly per directed case.
// Backpressure: mem_ack driven by the stimulus; monitor pops one expected event per DUT event.

module tb_store_narrow;

  localparam int ADDR_W = 32;

  localparam int EV_WR   = 0;
  localparam int EV_DONE = 1;
  localparam int EV_MIS  = 2;
  localparam int EV_RD   = 3;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              done;
  logic              misalign;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ev_t;

  ev_t exp_q[$];

  store_narrow #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    e.be   = b;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the next expected event and checks it against what the DUT shows.
  task automatic pop_and_check(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event got=kind%0d exp=none", kind);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", 32'(kind), 32'(e.kind));
      if (kind == EV_WR) begin
        check("ev_wr_addr", mem_addr, e.addr);
        check("ev_wr_data", mem_wdata, e.data);
        check("ev_wr_be", {28'h0, mem_be}, {28'h0, e.be});
      end else if (kind == EV_RD) begin
        check("ev_rd_addr", mem_addr, e.addr);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we && mem_re) check("we_re_exclusive", 32'h1, 32'h0);
      if (mem_re && mem_ack) pop_and_check(EV_RD);
      if (mem_we && mem_ack) pop_and_check(EV_WR);
      if (done)              pop_and_check(EV_DONE);
      if (misalign)          pop_and_check(EV_MIS);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_size  = 2'b00;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    #3;
    // Reset state.
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_re", {31'h0, mem_re}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_be", {28'h0, mem_be}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_mis", {31'h0, misalign}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

`ifndef STORE_RMW_EN
    // Byte store, ack in the first WR cycle.
    push(EV_WR, 32'h0000_1000, 32'hABAB_ABAB, 4'b0100);
    push(EV_DONE, 32'h0, 32'h0, 4'h0);
    req_valid = 1'b1; req_addr = 32'h0000_1002; req_size = 2'b00; req_data = 32'h0000_00AB;
    tick();
    req_valid = 1'b0;
    check("byte_we", {31'h0, mem_we}, 32'h1);
    check("byte_addr", mem_addr, 32'h0000_1000);
    check("byte_ready_busy", {31'h0, req_ready}, 32'h0);
    check("byte_done_early", {31'h0, done}, 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("byte_done_lat2", {31'h0, done}, 32'h1);
    check("byte_we_off", {31'h0, mem_we}, 32'h0);
    check("byte_wdata_idle", mem_wdata, 32'h0);
    tick();
    check("byte_done_pulse", {31'h0, done}, 32'h0);

    // Half store, ack delayed three cycles: outputs held for four WR cycles.
    push(EV_WR, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    push(EV_DONE, 32'h0, 32'h0, 4'h0);
    req_valid = 1'b1; req_addr = 32'h0000_2002; req_size = 2'b01; req_data = 32'h0000_BEEF;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF; req_data = 32'h0; req_size = 2'b10;
    for (int i = 0; i < 4; i++) begin
      check("half_we_held", {31'h0, mem_we}, 32'h1);
      check("half_wdata_held", mem_wdata, 32'hBEEF_BEEF);
      check("half_be_held", {28'h0, mem_be}, 32'hC);
      check("half_ready_busy", {31'h0, req_ready}, 32'h0);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    check("half_done", {31'h0, done}, 32'h1);
    tick();
    check("half_done_pulse", {31'h0, done}, 32'h0);
`else
    // Read-modify-write byte store.
    mem_rdata = 32'h1122_3344;
    push(EV_RD, 32'h0000_3000, 32'h0, 4'h0);
    push(EV_WR, 32'h0000_3000, 32'h1122_5A44, 4'b1111);
    push(EV_DONE, 32'h0, 32'h0, 4'h0);
    req_valid = 1'b1; req_addr = 32'h0000_3001; req_size = 2'b00; req_data = 32'h0000_005A;
    tick();
    req_valid = 1'b0;
    check("rmw_re", {31'h0, mem_re}, 32'h1);
    check("rmw_we_in_rd", {31'h0, mem_we}, 32'h0);
    check("rmw_be_in_rd", {28'h0, mem_be}, 32'h0);
    mem_ack = 1'b1;
    tick();
    check("rmw_we", {31'h0, mem_we}, 32'h1);
    check("rmw_re_off", {31'h0, mem_re}, 32'h0);
    check("rmw_be", {28'h0, mem_be}, 32'hF);
    check("rmw_wdata", mem_wdata, 32'h1122_5A44);
    check("rmw_done_early", {31'h0, done}, 32'h0);
    tick();
    mem_ack = 1'b0;
    check("rmw_done_lat3", {31'h0, done}, 32'h1);
    tick();
    mem_rdata = 32'h0;
`endif

    // Misaligned word then reserved size: two fault pulses, no memory access.
    push(EV_MIS, 32'h0, 32'h0, 4'h0);
    push(EV_MIS, 32'h0, 32'h0, 4'h0);
    req_valid = 1'b1; req_addr = 32'h0000_0001; req_size = 2'b10; req_data = 32'h1234_5678;
    tick();
    check("mis1_pulse", {31'h0, misalign}, 32'h1);
    check("mis1_ready", {31'h0, req_ready}, 32'h1);
    check("mis1_we", {31'h0, mem_we}, 32'h0);
    req_addr = 32'h0000_0000; req_size = 2'b11;
    tick();
    req_valid = 1'b0;
    check("mis2_pulse", {31'h0, misalign}, 32'h1);
    check("mis2_we", {31'h0, mem_we}, 32'h0);
    tick();
    check("mis_pulse_end", {31'h0, misalign}, 32'h0);
    check("mis_we_never", {31'h0, mem_we}, 32'h0);
    check("mis_done_never", {31'h0, done}, 32'h0);

    // Back-to-back word stores, ack held high (also exercises ack ignored in IDLE).
    push(EV_WR, 32'h0000_0100, 32'h1111_1111, 4'b1111);
    push(EV_DONE, 32'h0, 32'h0, 4'h0);
    push(EV_WR, 32'h0000_0104, 32'h2222_2222, 4'b1111);
    push(EV_DONE, 32'h0, 32'h0, 4'h0);
    mem_ack   = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_0100; req_size = 2'b10; req_data = 32'h1111_1111;
    tick();
    req_addr = 32'h0000_0104; req_data = 32'h2222_2222;
    check("b2b_first_we", {31'h0, mem_we}, 32'h1);
    tick();
    check("b2b_done1", {31'h0, done}, 32'h1);
    check("b2b_ready_in_done", {31'h0, req_ready}, 32'h1);
    tick();
    req_valid = 1'b0;
    check("b2b_second_we", {31'h0, mem_we}, 32'h1);
    check("b2b_second_addr", mem_addr, 32'h0000_0104);
    tick();
    check("b2b_done2", {31'h0, done}, 32'h1);
    tick();
    check("ack_ignored_idle", {31'h0, mem_we}, 32'h0);
    check("b2b_done_end", {31'h0, done}, 32'h0);
    mem_ack = 1'b0;

    // Reset while waiting for ack in WR, then a late ack.
    req_valid = 1'b1; req_addr = 32'h0000_0200; req_size = 2'b10; req_data = 32'h3333_3333;
    tick();
    req_valid = 1'b0;
    check("rstwr_we_before", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstwr_we", {31'h0, mem_we}, 32'h0);
    check("rstwr_addr", mem_addr, 32'h0);
    check("rstwr_wdata", mem_wdata, 32'h0);
    check("rstwr_be", {28'h0, mem_be}, 32'h0);
    check("rstwr_ready", {31'h0, req_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("late_ack_done", {31'h0, done}, 32'h0);
    check("late_ack_we", {31'h0, mem_we}, 32'h0);
    check("late_ack_ready", {31'h0, req_ready}, 32'h1);
    tick();
    check("late_ack_done2", {31'h0, done}, 32'h0);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
